// File: rtl/instr_register_pkg.sv
// Shared types for the instruction queue: opcode encoding, default widths and
// the completed-instruction word layout.
package instr_register_pkg;

  localparam int DEFAULT_DEPTH    = 32;
  localparam int DEFAULT_OP_WIDTH = 32;
  localparam int OPC_W            = 4;

  typedef enum logic [OPC_W-1:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MUL   = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [DEFAULT_OP_WIDTH-1:0]   operand_t;
  typedef logic signed [2*DEFAULT_OP_WIDTH-1:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  res;
    logic     err;
  } exec_word_t;

  // Packed width of {opc, op_a, op_b, res, err} for an arbitrary operand width.
  function automatic int word_width(int op_w);
    return OPC_W + 2 * op_w + 2 * op_w + 1;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational execute stage: signed arithmetic on sign-extended operands,
// with an error flag for divide-by-zero and unknown opcodes.
module exec_alu
  import instr_register_pkg::*;
#(
  parameter  int OP_WIDTH  = DEFAULT_OP_WIDTH,
  localparam int RES_WIDTH = 2 * OP_WIDTH
) (
  input  opcode_t                       opc_i,
  input  logic signed [OP_WIDTH-1:0]    a_i,
  input  logic signed [OP_WIDTH-1:0]    b_i,
  output logic signed [RES_WIDTH-1:0]   res_o,
  output logic                          err_o
);

  logic signed [RES_WIDTH-1:0] a_ext;
  logic signed [RES_WIDTH-1:0] b_ext;
  logic signed [RES_WIDTH-1:0] b_safe;
  logic                        b_zero;

  assign a_ext  = {{OP_WIDTH{a_i[OP_WIDTH-1]}}, a_i};
  assign b_ext  = {{OP_WIDTH{b_i[OP_WIDTH-1]}}, b_i};
  assign b_zero = (b_i == '0);
  // Divisor forced non-zero so the divider never sees 0; the result is discarded then.
  assign b_safe = b_zero ? RES_WIDTH'(1) : b_ext;

  always_comb begin
    res_o = '0;
    err_o = 1'b0;
    case (opc_i)
      ZERO:  res_o = '0;
      PASSA: res_o = a_ext;
      PASSB: res_o = b_ext;
      ADD:   res_o = a_ext + b_ext;
      SUB:   res_o = a_ext - b_ext;
      MUL:   res_o = a_ext * b_ext;
      DIV: begin
        if (b_zero) err_o = 1'b1;
        else        res_o = a_ext / b_safe;
      end
      MOD: begin
        if (b_zero) err_o = 1'b1;
        else        res_o = a_ext % b_safe;
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_exec_queue.sv
// Instruction queue: one registered execute stage feeding a circular buffer of
// completed instruction words that drains in order.
module instr_exec_queue
  import instr_register_pkg::*;
#(
  parameter  int DEPTH     = DEFAULT_DEPTH,
  parameter  int OP_WIDTH  = DEFAULT_OP_WIDTH,
  localparam int RES_WIDTH = 2 * OP_WIDTH,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int WORD_W    = word_width(OP_WIDTH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  opcode_t                    opcode,
  input  logic signed [OP_WIDTH-1:0] operand_a,
  input  logic signed [OP_WIDTH-1:0] operand_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_word,
  output logic [CNT_W-1:0]           count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    opcode_t                      opc;
    logic signed [OP_WIDTH-1:0]   op_a;
    logic signed [OP_WIDTH-1:0]   op_b;
    logic signed [RES_WIDTH-1:0]  res;
    logic                         err;
  } word_t;

  logic                       stage_valid_q, stage_valid_d;
  opcode_t                    stage_opc_q;
  logic signed [OP_WIDTH-1:0] stage_a_q, stage_b_q;
  word_t                      mem_q [DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           buf_cnt_q, buf_cnt_d, occ;
  logic signed [RES_WIDTH-1:0] alu_res;
  logic                       alu_err;
  logic                       accept, pop;

  exec_alu #(.OP_WIDTH(OP_WIDTH)) u_alu (
    .opc_i (stage_opc_q),
    .a_i   (stage_a_q),
    .b_i   (stage_b_q),
    .res_o (alu_res),
    .err_o (alu_err)
  );

  // Handshake: a transfer happens on a rising edge where valid && ready on that
  // port. in_ready counts the in-flight stage so the buffer can never overflow,
  // and it also rises combinationally when the head is popped in the same cycle.
  assign occ       = buf_cnt_q + CNT_W'(stage_valid_q);
  assign out_valid = (buf_cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = (occ < CNT_W'(DEPTH)) || pop;
  assign accept    = in_valid && in_ready;
  assign count     = occ;
  assign out_word  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    stage_valid_d = accept;
    wr_ptr_d      = wr_ptr_q + PTR_W'(stage_valid_q);
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    buf_cnt_d     = buf_cnt_q + CNT_W'(stage_valid_q) - CNT_W'(pop);
    if (flush) begin
      stage_valid_d = 1'b0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      buf_cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      buf_cnt_q     <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      buf_cnt_q     <= buf_cnt_d;
    end
  end

  // Payload storage needs no reset: validity lives entirely in the control regs.
  always_ff @(posedge clk) begin
    if (accept) begin
      stage_opc_q <= opcode;
      stage_a_q   <= operand_a;
      stage_b_q   <= operand_b;
    end
    if (stage_valid_q && !flush) begin
      mem_q[wr_ptr_q] <= '{opc: stage_opc_q, op_a: stage_a_q, op_b: stage_b_q,
                           res: alu_res, err: alu_err};
    end
  end

endmodule

// File: tb/tb_instr_exec_queue.sv
// Self-checking bench for instr_exec_queue: directed vector table, scoreboard
// of expected output words, full/wrap streaming, flush and async reset.
module tb_instr_exec_queue;
  import instr_register_pkg::*;

  localparam int DEPTH = 32;
  localparam int OP_W  = 32;
  localparam int RES_W = 64;
  localparam int CNT_W = 6;
  localparam int W     = OPC_W + 2 * OP_W + RES_W + 1;

  logic                    clk;
  logic                    reset_n;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  opcode_t                 opcode;
  logic signed [OP_W-1:0]  operand_a;
  logic signed [OP_W-1:0]  operand_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [W-1:0]            out_word;
  logic [CNT_W-1:0]        count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [W-1:0] exp_q[$];

  instr_exec_queue #(.DEPTH(DEPTH), .OP_WIDTH(OP_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .count     (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk_word(opcode_t op, logic signed [OP_W-1:0] a,
                                           logic signed [OP_W-1:0] b,
                                           logic signed [RES_W-1:0] r, logic e);
    return {op, a, b, r, e};
  endfunction

  function automatic logic signed [RES_W-1:0] model(opcode_t op, logic signed [OP_W-1:0] a,
                                                    logic signed [OP_W-1:0] b);
    logic signed [RES_W-1:0] ae, be;
    ae = a;
    be = b;
    case (op)
      PASSA:   return ae;
      PASSB:   return be;
      ADD:     return ae + be;
      SUB:     return ae - be;
      MUL:     return ae * be;
      default: return '0;
    endcase
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_n(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) fail("sb_unexpected_pop");
      else chk("sb_word", out_word, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(opcode_t op, logic signed [OP_W-1:0] a, logic signed [OP_W-1:0] b,
                      logic signed [RES_W-1:0] r, logic e);
    int t;
    t         = 0;
    opcode    = op;
    operand_a = a;
    operand_b = b;
    in_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 100) break;
    end
    if (t > 100) fail("push_timeout");
    else exp_q.push_back(mk_word(op, a, b, r, e));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_rand();
    opcode_t rops [5];
    opcode_t op;
    logic signed [OP_W-1:0] a, b;
    rops = '{ADD, SUB, MUL, PASSA, PASSB};
    op   = rops[$urandom_range(0, 4)];
    a    = $urandom();
    b    = $urandom();
    push(op, a, b, model(op, a, b), 1'b0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    out_ready = 1'b0;
    if (t >= 200) fail("drain_timeout");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    opcode_t                op;
    logic signed [OP_W-1:0]  a;
    logic signed [OP_W-1:0]  b;
    logic signed [RES_W-1:0] res;
    logic                    err;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int start;

    vecs[0]  = '{MUL,   32'sh7FFFFFFF, 32'sd2,  64'sh00000000FFFFFFFE, 1'b0};
    vecs[1]  = '{DIV,   -32'sd9,       32'sd2,  -64'sd4,               1'b0};
    vecs[2]  = '{MOD,   -32'sd9,       32'sd2,  -64'sd1,               1'b0};
    vecs[3]  = '{DIV,   32'sd10,       32'sd0,  64'sd0,                1'b1};
    vecs[4]  = '{MOD,   32'sd3,        32'sd0,  64'sd0,                1'b1};
    vecs[5]  = '{ZERO,  32'sd123,      32'sd456, 64'sd0,               1'b0};
    vecs[6]  = '{PASSA, -32'sd1,       32'sd7,  -64'sd1,               1'b0};
    vecs[7]  = '{PASSB, 32'sd3,        -32'sd8, -64'sd8,               1'b0};
    vecs[8]  = '{SUB,   32'sh80000000, 32'sd1,  64'shFFFFFFFF7FFFFFFF, 1'b0};
    vecs[9]  = '{MUL,   -32'sd3,       32'sd4,  -64'sd12,              1'b0};
    vecs[10] = '{DIV,   32'sh80000000, -32'sd1, 64'sh0000000080000000, 1'b0};
    vecs[11] = '{MOD,   32'sd7,        -32'sd3, 64'sd1,                1'b0};
    vecs[12] = '{opcode_t'(4'd12), 32'sd5, 32'sd6, 64'sd0,             1'b1};

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = ZERO;
    operand_a = '0;
    operand_b = '0;

    // 1. reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_n("rst_count", int'(count), 0);
    chk_n("rst_out_valid", int'(out_valid), 0);
    chk_n("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_word", out_word, '0);

    // 2. two-cycle latency of a single ADD
    push(ADD, 32'sd5, -32'sd7, -64'sd2, 1'b0);
    chk_n("lat_valid_n", int'(out_valid), 0);
    chk_n("lat_count_n", int'(count), 1);
    @(posedge clk);
    #1;
    chk_n("lat_valid_n1", int'(out_valid), 1);
    chk_n("lat_count_n1", int'(count), 1);
    chk("lat_word", out_word, mk_word(ADD, 32'sd5, -32'sd7, -64'sd2, 1'b0));
    drain();
    chk_n("lat_drained", int'(count), 0);

    // 3/4. arithmetic and error vectors
    foreach (vecs[i]) push(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err);
    chk_n("tbl_count", int'(count), 13);
    drain();
    chk_n("tbl_drained_count", int'(count), 0);
    chk_n("tbl_drained_valid", int'(out_valid), 0);

    // 5. fill to DEPTH, stall, then stream through pointer wrap
    for (int i = 0; i < DEPTH; i++) push_rand();
    chk_n("full_count", int'(count), DEPTH);
    chk_n("full_in_ready", int'(in_ready), 0);
    opcode    = ADD;
    operand_a = 32'sd1;
    operand_b = 32'sd1;
    in_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_n("full_stall_count", int'(count), DEPTH);
    chk_n("full_stall_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    start     = cyc;
    for (int i = 0; i < 40; i++) push_rand();
    chk_n("stream_cycles", cyc - start, 40);
    chk_n("stream_count", int'(count), DEPTH);
    drain();
    chk_n("stream_drained", int'(count), 0);

    // 6a. flush with a simultaneous push
    for (int i = 0; i < 10; i++) push_rand();
    @(posedge clk);
    #1;
    chk_n("pre_flush_count", int'(count), 10);
    flush     = 1'b1;
    in_valid  = 1'b1;
    opcode    = ADD;
    operand_a = 32'sd1;
    operand_b = 32'sd1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk_n("flush_count", int'(count), 0);
    chk_n("flush_out_valid", int'(out_valid), 0);
    chk_n("flush_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    chk_n("flush_discard_count", int'(count), 0);
    chk_n("flush_discard_valid", int'(out_valid), 0);
    push(SUB, 32'sd100, 32'sd58, 64'sd42, 1'b0);
    drain();

    // 6b. asynchronous reset mid-stream with an instruction in flight
    for (int i = 0; i < 10; i++) push_rand();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk_n("arst_count", int'(count), 0);
    chk_n("arst_out_valid", int'(out_valid), 0);
    chk_n("arst_in_ready", int'(in_ready), 1);
    chk("arst_out_word", out_word, '0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_n("arst_after_count", int'(count), 0);
    push(MOD, -32'sd7, 32'sd3, -64'sd1, 1'b0);
    drain();
    chk_n("final_count", int'(count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_exec_queue.md
Name: instr_exec_queue

Overview:
Parametrised successor of the instruction register: a valid/ready instruction queue with a registered execute stage and a circular buffer of completed instruction words.
- Upstream pushes opcode plus two operands; the block computes the result one stage later and stores opcode, operands, result and error flag.
- Entries drain in order through a valid/ready output port.
- Sits between the instruction generator/testbench driver and any downstream consumer or checker.

Parameters:
DEPTH, 32, number of result-buffer entries; power of two, at least 2
OP_WIDTH, 32, signed operand width
RES_WIDTH, 2*OP_WIDTH, localparam, signed result width
CNT_W, $clog2(DEPTH+1), localparam, occupancy counter width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of pipeline and buffer
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept an instruction
opcode  in  opcode_t  operation
operand_a  in  OP_WIDTH  signed operand A
operand_b  in  OP_WIDTH  signed operand B
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head entry
out_word  out  exec_word_t  head entry {opc, op_a, op_b, res, err}
count  out  CNT_W  entries in buffer plus in-flight stage

Behaviour:
- Reset (async assert, sync release) and flush:
  - Clear stage valid, write pointer, read pointer and occupancy.
  - Outputs after reset: out_valid=0, count=0, in_ready=1, out_word='{opc:ZERO, default:0}.
  - flush has priority over push/pop in the same cycle.
  - A reset mid-stream discards all entries, including any in-flight instruction.
- Transfer rules:
  - Accept occurs when in_valid && in_ready at a rising edge.
  - Pop occurs when out_valid && out_ready.
  - Upstream must hold its inputs stable while in_valid && !in_ready. The block does not check this.
- Stage 1:
  - An accepted instruction is captured into the stage register (stage_valid=1) at edge N.
- Stage 2:
  - At edge N+1 the result is computed combinationally from the stage register and written to buf[wr_ptr].
  - wr_ptr then increments modulo DEPTH.
- Latency:
  - With the buffer empty, out_valid rises after edge N+1, i.e. 2 cycles after acceptance.
  - Throughput is one instruction per cycle.
- Occupancy:
  - occ = buffer entries + stage_valid; count = occ.
  - in_ready = (occ < DEPTH) || (pop this cycle); pop-to-ready is a combinational path.
  - The in-flight stage is always counted, so the buffer never overflows.
- Empty/full:
  - out_valid = (buffer entries != 0).
  - out_word = buf[rd_ptr]; it is unregistered and held stable while !out_ready.
  - Pop with empty buffer is impossible because out_valid=0.
- Simultaneous events:
  - Stage write and pop in the same cycle leave the buffer count unchanged.
  - Accept, stage write and pop in the same cycle are legal at full.
- Pointers wrap from DEPTH-1 to 0.
- Arithmetic (signed two's complement; operands sign-extended to RES_WIDTH):
  - ZERO: res=0
  - PASSA: res=a
  - PASSB: res=b
  - ADD: res=a+b
  - SUB: res=a-b
  - MUL: res=a*b, full width
  - DIV: res=a/b, truncating toward zero
  - MOD: res=a%b, sign follows a
- Error cases:
  - DIV or MOD with b==0: res=0, err=1.
  - Any other opcode encoding: res=0, err=1.
  - All other cases: err=0.

Decomposition:
- instr_register_pkg additions:
  - Parametrisable widths.
  - exec_word_t struct {opcode_t opc; operand_t op_a; operand_t op_b; result_t res; logic err}.
  - Opcode enum unchanged.
  - Localparam DEFAULT_DEPTH=32.
- Sub-module exec_alu: purely combinational stage-2 computation, producing res and err.
- The top module holds the stage register, the buffer array, pointers, the occupancy counter and the handshake logic.

Test Plan:
1. Reset then idle -> count=0, out_valid=0, in_ready=1, out_word.opc=ZERO.
2. Push ADD a=5 b=-7 with out_ready=0 -> out_valid after 2 cycles; res=-2, err=0, count=1.
3. Push MUL a=32'h7FFFFFFF b=2 -> res=64'h00000000FFFFFFFE; then DIV a=-9 b=2 -> res=-4; then MOD a=-9 b=2 -> res=-1.
4. DIV a=10 b=0 and MOD a=3 b=0 -> res=0, err=1 for each.
5. Push 32 instructions with out_ready=0 -> in_ready=0 once count=32. Assert out_ready with in_valid=1 -> one pop and one accept per cycle; in-order data across pointer wrap.
6. Fill 10 entries, pulse flush with in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, pushed instruction discarded. Repeat with reset_n asserted asynchronously mid-stream -> same outputs immediately.
